// File: rtl/seq_mul_div.sv
// rtl/seq_mul_div.sv - radix-2 iterative unsigned multiplier / restoring divider
module seq_mul_div #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             op_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic             div_by_zero;

  assign div_by_zero = Op && (B == '0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: if (Start) state_nxt = div_by_zero ? DONE : CALC;
      CALC: begin
        Busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration of either algorithm; {hi, lo} holds {Hi, Lo} or {R, Q}.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : '0);
    div_rem  = {hi, lo[WIDTH-1]};
    div_ge   = (div_rem >= {1'b0, b_reg});
    // Remainder after subtraction is always below the divisor, so WIDTH bits suffice.
    div_diff = div_rem[WIDTH-1:0] - b_reg;
    if (op_reg) begin
      hi_nxt = div_ge ? div_diff : div_rem[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt      <= '0;
      op_reg   <= 1'b0;
      b_reg    <= '0;
      hi       <= '0;
      lo       <= '0;
      Result   <= '0;
      ResultHi <= '0;
      DivZero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            op_reg  <= Op;
            b_reg   <= B;
            cnt     <= '0;
            hi      <= '0;
            lo      <= A;
            DivZero <= div_by_zero;
            if (div_by_zero) begin
              Result   <= '1;
              ResultHi <= A;
            end
          end
        end
        CALC: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            Result   <= lo_nxt;
            ResultHi <= hi_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_div.sv
// tb/tb_seq_mul_div.sv - table-driven self-checking bench for seq_mul_div
module tb_seq_mul_div;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        Op    = 1'b0;
  logic [15:0] A     = '0;
  logic [15:0] B     = '0;
  logic        Busy, Done, DivZero;
  logic [15:0] Result, ResultHi;

  int total = 0;
  int bad   = 0;

  seq_mul_div #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Result(Result), .ResultHi(ResultHi), .DivZero(DivZero)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] hi;
    logic        dz;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one Start at the next edge, then watch 40 cycles; k counts negedges after edge E0.
  task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                        output int busy_n, output int done_n, output int done_k);
    busy_n = 0; done_n = 0; done_k = -1;
    @(negedge Clock);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clock);
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (k == 0) begin
        Start = 1'b0; Op = ~op; A = 16'h5A5A; B = 16'hA5A5;
      end
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
    end
  endtask

  initial begin
    int busy_n, done_n, done_k;

    vecs[0]  = '{1'b0, 16'd300,   16'd200,   16'hEA60, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 16'hFFFF,  16'hFFFF,  16'h0001, 16'hFFFE, 1'b0};
    vecs[2]  = '{1'b1, 16'd1000,  16'd7,     16'd142,  16'd6,    1'b0};
    vecs[3]  = '{1'b1, 16'd5,     16'd9,     16'd0,    16'd5,    1'b0};
    vecs[4]  = '{1'b1, 16'd1234,  16'd0,     16'hFFFF, 16'd1234, 1'b1};
    vecs[5]  = '{1'b0, 16'd0,     16'd1234,  16'h0000, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 16'd1000,  16'd1000,  16'h4240, 16'h000F, 1'b0};
    vecs[7]  = '{1'b1, 16'hFFFF,  16'd1,     16'hFFFF, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 16'd12345, 16'd123,   16'd100,  16'd45,   1'b0};
    vecs[9]  = '{1'b1, 16'hFFFF,  16'hFFFF,  16'd1,    16'd0,    1'b0};
    vecs[10] = '{1'b0, 16'd1234,  16'd0,     16'h0000, 16'h0000, 1'b0};

    #12;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_result", {16'd0, Result}, 32'd0);
    chk("rst_resulthi", {16'd0, ResultHi}, 32'd0);
    chk("rst_divzero", {31'd0, DivZero}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, busy_n, done_n, done_k);
      chk($sformatf("v%0d_result", i), {16'd0, Result}, {16'd0, vecs[i].res});
      chk($sformatf("v%0d_resulthi", i), {16'd0, ResultHi}, {16'd0, vecs[i].hi});
      chk($sformatf("v%0d_divzero", i), {31'd0, DivZero}, {31'd0, vecs[i].dz});
      chk($sformatf("v%0d_done_cnt", i), done_n, 32'd1);
      chk($sformatf("v%0d_done_at", i), done_k, vecs[i].dz ? 32'd0 : 32'd16);
      chk($sformatf("v%0d_busy_cnt", i), busy_n, vecs[i].dz ? 32'd0 : 32'd16);
    end

    // Start pulses while Busy and while Done must be ignored.
    busy_n = 0; done_n = 0; done_k = -1;
    @(negedge Clock);
    Start = 1'b1; Op = 1'b0; A = 16'd3; B = 16'd4;
    @(posedge Clock);
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      Start = (k == 4) || (k == 16);
      Op = 1'b1; A = 16'd9; B = 16'd3;
    end
    chk("ign_result", {16'd0, Result}, 32'd12);
    chk("ign_resulthi", {16'd0, ResultHi}, 32'd0);
    chk("ign_done_cnt", done_n, 32'd1);
    chk("ign_done_at", done_k, 32'd16);
    chk("ign_busy_cnt", busy_n, 32'd16);

    // Asynchronous reset in the middle of a multiply.
    done_n = 0;
    @(negedge Clock);
    Start = 1'b1; Op = 1'b0; A = 16'd7; B = 16'd9;
    @(posedge Clock);
    for (int k = 0; k < 8; k++) begin
      @(negedge Clock);
      Start = 1'b0;
      if (Done) done_n++;
    end
    chk("mid_busy_before", {31'd0, Busy}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("mid_busy", {31'd0, Busy}, 32'd0);
    chk("mid_done", {31'd0, Done}, 32'd0);
    chk("mid_result", {16'd0, Result}, 32'd0);
    chk("mid_resulthi", {16'd0, ResultHi}, 32'd0);
    chk("mid_divzero", {31'd0, DivZero}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge Clock);
      if (Done || Busy) done_n++;
    end
    chk("mid_no_done", done_n, 32'd0);

    run_op(1'b0, 16'd7, 16'd9, busy_n, done_n, done_k);
    chk("post_result", {16'd0, Result}, 32'd63);
    chk("post_resulthi", {16'd0, ResultHi}, 32'd0);
    chk("post_done_cnt", done_n, 32'd1);
    chk("post_done_at", done_k, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
